mem_line_xfer: RTL and testbench

// - Initiator side of the word-addressed memory port: turns one cache-line request into W word accesses.
// - Optional dirty-line writeback first (W write cycles), then line fill (W read cycles); returns filled line.
// - Sits between the cache controller (req/resp handshake) and the main memory array (wr_en/addr/data/data_out).
// - Memory read data is combinational from mem_addr; write commits on the clk edge.

---
 rtl/cache_mem_pkg.sv | 24 ++
 rtl/mem_line_xfer.sv | 120 ++++++++++++
 tb/tb_mem_line_xfer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_pkg.sv
// Shared types and helpers for the cache line transfer engine.
package cache_mem_pkg;

    localparam int WORD_W              = 32;
    localparam int DEF_WORDS_PER_LINE  = 4;

    // Transfer engine states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        RESP = 2'd3
    } xfer_state_t;

    // Line at the default geometry; modules with other W build their own width.
    typedef logic [WORD_W*DEF_WORDS_PER_LINE-1:0] line_t;

    // Clear the word-offset bits of a word address to get its line base.
    function automatic logic [63:0] line_base(input logic [63:0] addr,
                                              input int unsigned offs_w);
        return addr & ~((64'd1 << offs_w) - 64'd1);
    endfunction

endpackage

// File: rtl/mem_line_xfer.sv
// Initiator side of the word-addressed memory port: one cache-line request
// becomes an optional W-word writeback followed by a W-word fill.
module mem_line_xfer
    import cache_mem_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_wb,
    input  logic [ADDR_WIDTH-1:0]            req_fill_addr,
    input  logic [ADDR_WIDTH-1:0]            req_wb_addr,
    input  logic [WORD_W*WORDS_PER_LINE-1:0] req_wb_line,
    output logic                             resp_valid,
    input  logic                             resp_ready,
    output logic [WORD_W*WORDS_PER_LINE-1:0] resp_line,
    output logic                             busy,
    output logic                             mem_wr_en,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [WORD_W-1:0]                mem_data,
    input  logic [WORD_W-1:0]                mem_data_in
);

    localparam int OFFS_W = $clog2(WORDS_PER_LINE);
    localparam int LINE_W = WORD_W * WORDS_PER_LINE;
    localparam logic [OFFS_W-1:0] LAST_WORD = OFFS_W'(WORDS_PER_LINE - 1);

    xfer_state_t              state_q, state_d;
    logic [OFFS_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]    wb_base_q, wb_base_d;
    logic [ADDR_WIDTH-1:0]    fill_base_q, fill_base_d;
    logic [LINE_W-1:0]        wb_line_q, wb_line_d;
    logic [LINE_W-1:0]        buf_q, buf_d;

    // Next-state logic: request capture, word sequencing and fill capture.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        cnt_d       = cnt_q;
        wb_base_d   = wb_base_q;
        fill_base_d = fill_base_q;
        wb_line_d   = wb_line_q;
        buf_d       = buf_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wb_base_d   = ADDR_WIDTH'(line_base(64'(req_wb_addr), OFFS_W));
                    fill_base_d = ADDR_WIDTH'(line_base(64'(req_fill_addr), OFFS_W));
                    wb_line_d   = req_wb_line;
                    cnt_d       = '0;
                    state_d     = req_wb ? WB : FILL;
                end
            end
            WB: begin
                // Counter wraps to 0 naturally after the last word.
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_WORD) state_d = FILL;
            end
            FILL: begin
                buf_d[WORD_W*cnt_q +: WORD_W] = mem_data_in;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_WORD) state_d = RESP;
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            // NOTE: the line buffer is reset too because it drives resp_line, which must read 0 after reset.
            state_q     <= IDLE;
            cnt_q       <= '0;
            wb_base_q   <= '0;
            fill_base_q <= '0;
            wb_line_q   <= '0;
            buf_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wb_base_q   <= wb_base_d;
            fill_base_q <= fill_base_d;
            wb_line_q   <= wb_line_d;
            buf_q       <= buf_d;
        end
    end

    // Output decode from registered state only; no path from req_* to the memory port.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        busy       = (state_q != IDLE);
        mem_wr_en  = 1'b0;
        mem_addr   = '0;
        mem_data   = '0;
        resp_line  = buf_q;

        case (state_q)
            IDLE: req_ready = 1'b1;
            WB: begin
                // Gating with rst makes a reset abort before the edge commits another word.
                mem_wr_en = ~rst;
                mem_addr  = wb_base_q + ADDR_WIDTH'(cnt_q);
                mem_data  = wb_line_q[WORD_W*cnt_q +: WORD_W];
            end
            FILL: mem_addr = fill_base_q + ADDR_WIDTH'(cnt_q);
            RESP: resp_valid = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_line_xfer.sv
// Directed self-checking bench for mem_line_xfer with a small word memory.
module tb_mem_line_xfer;

    localparam int AW = 32;
    localparam int W  = 4;
    localparam int LW = 32 * W;
    localparam int MEM_SIZE = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_wb;
    logic [AW-1:0] req_fill_addr, req_wb_addr;
    logic [LW-1:0] req_wb_line;
    logic          resp_valid, resp_ready;
    logic [LW-1:0] resp_line;
    logic          busy, mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_data, mem_data_in;

    logic [31:0]   mem [0:MEM_SIZE-1];
    logic          bd_we;
    logic [9:0]    bd_addr;
    logic [31:0]   bd_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [LW-1:0] exp_line;

    mem_line_xfer #(.ADDR_WIDTH(AW), .WORDS_PER_LINE(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wb(req_wb),
        .req_fill_addr(req_fill_addr), .req_wb_addr(req_wb_addr),
        .req_wb_line(req_wb_line),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_line(resp_line),
        .busy(busy), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_data_in(mem_data_in)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read, write on the edge; backdoor for preload.
    assign mem_data_in = mem[mem_addr[9:0]];
    always @(posedge clk) begin
        if (mem_wr_en)  mem[mem_addr[9:0]] <= mem_data;
        else if (bd_we) mem[bd_addr] <= bd_data;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        tick();
        bd_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_wb = 1'b0; resp_ready = 1'b0;
        req_fill_addr = '0; req_wb_addr = '0; req_wb_line = '0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;

        // Reset for two cycles.
        tick(); tick();
        check("rst_req_ready",  LW'(req_ready),  LW'(1'b1));
        check("rst_busy",       LW'(busy),       LW'(1'b0));
        check("rst_resp_valid", LW'(resp_valid), LW'(1'b0));
        check("rst_wr_en",      LW'(mem_wr_en),  LW'(1'b0));
        check("rst_addr",       LW'(mem_addr),   LW'(0));
        check("rst_data",       LW'(mem_data),   LW'(0));
        check("rst_line",       resp_line,       '0);
        rst = 1'b0;

        for (int i = 0; i < W; i++) preload(10'h010 + 10'(i), 32'hA000_0000 + 32'(i));
        for (int i = 0; i < W; i++) preload(10'h040 + 10'(i), 32'hB000_0000 + 32'(i));
        check("idle_ready", LW'(req_ready), LW'(1'b1));

        // Fill only from an unaligned address inside line 0x10.
        req_valid = 1'b1; req_wb = 1'b0; req_fill_addr = 32'h12;
        tick();
        req_valid = 1'b0; req_fill_addr = 32'h3FF;
        check("fill_busy",  LW'(busy),      LW'(1'b1));
        check("fill_ready", LW'(req_ready), LW'(1'b0));
        for (int k = 0; k < W; k++) begin
            check($sformatf("fill_addr%0d", k),  LW'(mem_addr),   LW'(32'h10 + k));
            check($sformatf("fill_wr%0d", k),    LW'(mem_wr_en),  LW'(1'b0));
            check($sformatf("fill_rv%0d", k),    LW'(resp_valid), LW'(1'b0));
            tick();
        end
        exp_line = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
        check("fill_resp_valid", LW'(resp_valid), LW'(1'b1));
        check("fill_resp_line",  resp_line,       exp_line);
        check("fill_resp_addr",  LW'(mem_addr),   LW'(0));
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("fill_done_busy", LW'(busy),       LW'(1'b0));
        check("fill_done_rv",   LW'(resp_valid), LW'(1'b0));

        // Writeback of line 0x20 then fill of line 0x40.
        req_valid = 1'b1; req_wb = 1'b1; req_wb_addr = 32'h20; req_fill_addr = 32'h41;
        req_wb_line = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
        tick();
        req_valid = 1'b0; req_wb = 1'b0; req_wb_line = {4{32'hDEAD_BEEF}}; req_wb_addr = 32'h300;
        for (int k = 0; k < W; k++) begin
            check($sformatf("wb_wr%0d", k),   LW'(mem_wr_en),  LW'(1'b1));
            check($sformatf("wb_addr%0d", k), LW'(mem_addr),   LW'(32'h20 + k));
            check($sformatf("wb_data%0d", k), LW'(mem_data),   LW'(32'hD000_0000 + k));
            tick();
        end
        for (int k = 0; k < W; k++) begin
            check($sformatf("wbf_addr%0d", k), LW'(mem_addr),   LW'(32'h40 + k));
            check($sformatf("wbf_wr%0d", k),   LW'(mem_wr_en),  LW'(1'b0));
            check($sformatf("wbf_rv%0d", k),   LW'(resp_valid), LW'(1'b0));
            tick();
        end
        exp_line = {32'hB000_0003, 32'hB000_0002, 32'hB000_0001, 32'hB000_0000};
        check("wbf_resp_valid", LW'(resp_valid), LW'(1'b1));
        check("wbf_resp_line",  resp_line,       exp_line);
        for (int i = 0; i < W; i++)
            check($sformatf("wb_mem%0d", i), LW'(mem[10'h020 + 10'(i)]), LW'(32'hD000_0000 + i));
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // Same line for writeback and fill: fill returns the fresh data.
        req_valid = 1'b1; req_wb = 1'b1; req_wb_addr = 32'h33; req_fill_addr = 32'h30;
        req_wb_line = {32'd4, 32'd3, 32'd2, 32'd1};
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < 2 * W; k++) tick();
        check("same_resp_valid", LW'(resp_valid), LW'(1'b1));
        check("same_resp_line",  resp_line,       {32'd4, 32'd3, 32'd2, 32'd1});

        // Backpressure: hold resp_ready low; a second request must be ignored.
        req_valid = 1'b1; req_wb = 1'b0; req_fill_addr = 32'h10;
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("bp_rv%0d", c),    LW'(resp_valid), LW'(1'b1));
            check($sformatf("bp_line%0d", c),  resp_line,       {32'd4, 32'd3, 32'd2, 32'd1});
            check($sformatf("bp_ready%0d", c), LW'(req_ready),  LW'(1'b0));
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0; req_valid = 1'b0;
        check("bp_no_accept_busy", LW'(busy),      LW'(1'b0));
        check("bp_idle_ready",     LW'(req_ready), LW'(1'b1));

        // Reset during writeback after two committed words.
        req_valid = 1'b1; req_wb = 1'b1; req_wb_addr = 32'h20; req_fill_addr = 32'h40;
        req_wb_line = {32'hE000_0003, 32'hE000_0002, 32'hE000_0001, 32'hE000_0000};
        tick();
        req_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1;
        check("abort_wr_gated", LW'(mem_wr_en), LW'(1'b0));
        tick();
        rst = 1'b0;
        check("abort_busy",  LW'(busy),       LW'(1'b0));
        check("abort_ready", LW'(req_ready),  LW'(1'b1));
        check("abort_wr",    LW'(mem_wr_en),  LW'(1'b0));
        check("abort_addr",  LW'(mem_addr),   LW'(0));
        check("abort_rv",    LW'(resp_valid), LW'(1'b0));
        check("abort_line",  resp_line,       '0);
        check("abort_mem0",  LW'(mem[10'h020]), LW'(32'hE000_0000));
        check("abort_mem1",  LW'(mem[10'h021]), LW'(32'hE000_0001));
        check("abort_mem2",  LW'(mem[10'h022]), LW'(32'hD000_0002));
        check("abort_mem3",  LW'(mem[10'h023]), LW'(32'hD000_0003));
        tick();
        check("post_abort_wr", LW'(mem_wr_en), LW'(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
